// File: rtl/scaler_phase_gen.sv
// -----------------------------------------------------------------------------
// scaler_phase_gen
//
// Purpose:
//   Generates, for one video line, the source-pixel pair and interpolation
//   phase for every output pixel of a 1-D scaler (shrink or expand). Output j
//   is placed at source position pos = ((2j+1)*S - M) / (2M), which aligns
//   pixel centres. The integer part is found by repeated subtraction of 2M
//   and the fractional part by a short restoring division, so no hardware
//   divider is needed.
//
// Ports:
//   clk        : single clock, rising edge
//   reset      : synchronous, active-high; aborts any line in progress
//   start      : one-cycle pulse that begins a line (ignored unless idle)
//   cfg_s_nbr  : source pixel count S, sampled on an accepted start
//   cfg_m_nbr  : output pixel count M, sampled on an accepted start
//   busy       : high while a line is in progress
//   done       : one-cycle pulse after the last output is accepted
//   cfg_err    : one-cycle pulse when a start is rejected (S=0 or M=0)
//   m_valid    : output pair/phase is valid (registered)
//   m_ready    : downstream accepts the current output
//   m_i0/m_i1  : left/right source indices
//   m_phase    : weight of m_i1 in units of 2^-C_PHASE_BITS
//   m_idx      : output index j
//   m_first    : j == 0
//   m_last     : j == M-1
// -----------------------------------------------------------------------------
module scaler_phase_gen #(
  parameter int C_S_WIDTH    = 12,
  parameter int C_M_WIDTH    = 12,
  parameter int C_PHASE_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [C_S_WIDTH-1:0]    cfg_s_nbr,
  input  logic [C_M_WIDTH-1:0]    cfg_m_nbr,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [C_S_WIDTH-1:0]    m_i0,
  output logic [C_S_WIDTH-1:0]    m_i1,
  output logic [C_PHASE_BITS-1:0] m_phase,
  output logic [C_M_WIDTH-1:0]    m_idx,
  output logic                    m_first,
  output logic                    m_last
);

  // Remainder width: r can reach just under 2M + 2S after the advance step.
  localparam int RW = ((C_S_WIDTH > C_M_WIDTH) ? C_S_WIDTH : C_M_WIDTH) + 3;
  // Signed integer-part width: must hold -1 .. S.
  localparam int KW = C_S_WIDTH + 2;
  // Division step counter, enough for up to 8 phase bits.
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DIV  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                   state_reg;
  logic [C_S_WIDTH-1:0]     s_reg;
  logic [C_M_WIDTH-1:0]     m_reg;
  logic [RW-1:0]            r_reg;
  logic signed [KW-1:0]     k_reg;
  logic [C_M_WIDTH-1:0]     j_reg;
  logic [RW-1:0]            d_reg;
  logic [C_PHASE_BITS-1:0]  q_reg;
  logic [CW-1:0]            cnt_reg;

  logic                     busy_reg;
  logic                     done_reg;
  logic                     cfg_err_reg;
  logic                     m_valid_reg;
  logic [C_S_WIDTH-1:0]     m_i0_reg;
  logic [C_S_WIDTH-1:0]     m_i1_reg;
  logic [C_PHASE_BITS-1:0]  m_phase_reg;
  logic [C_M_WIDTH-1:0]     m_idx_reg;
  logic                     m_first_reg;
  logic                     m_last_reg;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic [RW-1:0]            two_m;
  logic [RW-1:0]            two_s;
  logic [RW-1:0]            r_init;
  logic                     r_ge;
  logic [RW-1:0]            d_dbl;
  logic                     d_ge;
  logic [C_S_WIDTH-1:0]     s_minus1;
  logic [C_M_WIDTH-1:0]     m_minus1;
  logic signed [KW-1:0]     s_last;
  logic                     k_neg;
  logic                     k_at_end;
  logic [C_S_WIDTH-1:0]     k_idx;
  logic [C_S_WIDTH-1:0]     k_idx_p1;
  logic [C_S_WIDTH-1:0]     clamp_idx;
  logic                     j_last;
  logic                     div_last;
  logic [C_PHASE_BITS-1:0]  q_next;

  assign two_m    = {{(RW-C_M_WIDTH-1){1'b0}}, m_reg, 1'b0};
  assign two_s    = {{(RW-C_S_WIDTH-1){1'b0}}, s_reg, 1'b0};
  // r starts at S+M = numerator of output 0 plus one 2M, paired with k = -1.
  assign r_init   = {{(RW-C_S_WIDTH){1'b0}}, cfg_s_nbr}
                  + {{(RW-C_M_WIDTH){1'b0}}, cfg_m_nbr};
  assign r_ge     = (r_reg >= two_m);

  // d < 2M always holds, so doubling never overflows RW bits.
  assign d_dbl    = d_reg << 1;
  assign d_ge     = (d_dbl >= two_m);

  assign s_minus1 = s_reg - C_S_WIDTH'(1);
  assign m_minus1 = m_reg - C_M_WIDTH'(1);
  assign s_last   = $signed({2'b00, s_minus1});
  assign k_neg    = k_reg[KW-1];
  assign k_at_end = (k_reg >= s_last);
  assign k_idx    = k_reg[C_S_WIDTH-1:0];
  assign k_idx_p1 = k_idx + C_S_WIDTH'(1);
  // Outside the source the output degenerates to a single edge pixel.
  assign clamp_idx = k_neg ? '0 : s_minus1;

  assign j_last   = (j_reg == m_minus1);
  assign div_last = (cnt_reg == CW'(C_PHASE_BITS - 1));

  // Quotient bits are produced MSB first; step n writes bit P-1-n.
  generate
    for (genvar gi = 0; gi < C_PHASE_BITS; gi++) begin : g_qbit
      assign q_next[gi] = (cnt_reg == CW'(C_PHASE_BITS - 1 - gi)) ? d_ge : q_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      s_reg       <= '0;
      m_reg       <= '0;
      r_reg       <= '0;
      k_reg       <= '0;
      j_reg       <= '0;
      d_reg       <= '0;
      q_reg       <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;
      m_valid_reg <= 1'b0;
      m_i0_reg    <= '0;
      m_i1_reg    <= '0;
      m_phase_reg <= '0;
      m_idx_reg   <= '0;
      m_first_reg <= 1'b0;
      m_last_reg  <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      cfg_err_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start) begin
            if ((cfg_s_nbr != '0) && (cfg_m_nbr != '0)) begin
              s_reg     <= cfg_s_nbr;
              m_reg     <= cfg_m_nbr;
              r_reg     <= r_init;
              k_reg     <= '1;          // -1
              j_reg     <= '0;
              busy_reg  <= 1'b1;
              state_reg <= NORM;
            end else begin
              cfg_err_reg <= 1'b1;
            end
          end
        end

        NORM: begin
          if (r_ge) begin
            // One 2M subtraction per cycle advances the integer position.
            r_reg <= r_reg - two_m;
            k_reg <= k_reg + KW'(1);
          end else if (k_neg || k_at_end) begin
            m_i0_reg    <= clamp_idx;
            m_i1_reg    <= clamp_idx;
            m_phase_reg <= '0;
            m_valid_reg <= 1'b1;
            m_idx_reg   <= j_reg;
            m_first_reg <= (j_reg == '0);
            m_last_reg  <= j_last;
            state_reg   <= OUT;
          end else begin
            m_i0_reg  <= k_idx;
            m_i1_reg  <= k_idx_p1;
            d_reg     <= r_reg;
            q_reg     <= '0;
            cnt_reg   <= '0;
            state_reg <= DIV;
          end
        end

        DIV: begin
          // Restoring division of r by 2M, one quotient bit per cycle.
          d_reg   <= d_ge ? (d_dbl - two_m) : d_dbl;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (div_last) begin
            m_phase_reg <= q_next;
            m_valid_reg <= 1'b1;
            m_idx_reg   <= j_reg;
            m_first_reg <= (j_reg == '0);
            m_last_reg  <= j_last;
            state_reg   <= OUT;
          end
        end

        OUT: begin
          if (m_ready) begin
            m_valid_reg <= 1'b0;
            if (j_last) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              // Next numerator is larger by 2S; r keeps the old remainder.
              j_reg     <= j_reg + C_M_WIDTH'(1);
              r_reg     <= r_reg + two_s;
              state_reg <= NORM;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign cfg_err = cfg_err_reg;
  assign m_valid = m_valid_reg;
  assign m_i0    = m_i0_reg;
  assign m_i1    = m_i1_reg;
  assign m_phase = m_phase_reg;
  assign m_idx   = m_idx_reg;
  assign m_first = m_first_reg;
  assign m_last  = m_last_reg;

endmodule

// File: doc/scaler_phase_gen.md
SCALER_PHASE_GEN -- requirements
Module: scaler_phase_gen

Interface
REQ-001 The block SHALL have parameter C_S_WIDTH, default 12, giving the source pixel count width.
REQ-002 The block SHALL have parameter C_M_WIDTH, default 12, giving the output pixel count width.
REQ-003 The block SHALL have parameter C_PHASE_BITS, default 4, range 1..8, giving the interpolation phase width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a line.
REQ-007 The block SHALL have port cfg_s_nbr, input, C_S_WIDTH bits: the source pixel count S, sampled only on an accepted start.
REQ-008 The block SHALL have port cfg_m_nbr, input, C_M_WIDTH bits: the output pixel count M, sampled only on an accepted start.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a line.
REQ-011 The block SHALL have port cfg_err, output, 1 bit: a one-cycle pulse when a start is rejected because S=0 or M=0.
REQ-012 The block SHALL have port m_valid, output, 1 bit; port m_ready, input, 1 bit: the output handshake.
REQ-013 The block SHALL have port m_i0, output, C_S_WIDTH bits: the left source index; port m_i1, output, C_S_WIDTH bits: the right source index.
REQ-014 The block SHALL have port m_phase, output, C_PHASE_BITS bits: the weight of m_i1, in units of 2^-C_PHASE_BITS.
REQ-015 The block SHALL have port m_idx, output, C_M_WIDTH bits: the output index j; port m_first, output, 1 bit: high when j=0; port m_last, output, 1 bit: high when j=M-1.

Function
REQ-016 The block SHALL map each output j to the source position pos=((2j+1)*S-M)/(2M) (pixel-centre alignment), for both shrink and expand.
REQ-017 The block SHALL keep internal registers: remainder r (unsigned, max(C_S_WIDTH,C_M_WIDTH)+3 bits), index k (signed, C_S_WIDTH+2 bits) and j; it SHALL use no hardware divider.
REQ-018 The block SHALL implement states IDLE, NORM, DIV and OUT, one transition per cycle at most.
REQ-019 In IDLE, on start with S>0 and M>0, the block SHALL latch S and M, set r=S+M, k=-1 and j=0, and go to NORM.
REQ-020 In IDLE, on start with S=0 or M=0, the block SHALL pulse cfg_err the next cycle, stay in IDLE and produce no output.
REQ-021 In NORM, if r>=2M, the block SHALL set r=r-2M and k=k+1 and stay in NORM; this is one subtraction per cycle.
REQ-022 In NORM, if r<2M and (k<0 or k>=S-1), the block SHALL go to OUT with m_phase=0 and both indices clamped: 0 if k<0, S-1 otherwise.
REQ-023 In NORM, if r<2M and 0<=k<S-1, the block SHALL go to DIV with i0=k and i1=k+1.
REQ-024 DIV SHALL last exactly C_PHASE_BITS cycles of restoring division: copy d=r, then each cycle d=2d; if d>=2M, shift in 1 and set d=d-2M, else shift in 0. The result SHALL be m_phase=floor(r*2^P/(2M)). After the last cycle the block SHALL go to OUT.
REQ-025 In OUT, m_valid SHALL be 1, and m_i0, m_i1, m_phase, m_idx, m_first and m_last SHALL stay stable until m_valid and m_ready are both high.
REQ-026 On a handshake with j<M-1, the block SHALL set j=j+1 and r=r+2S and go to NORM.
REQ-027 On a handshake with j=M-1, the block SHALL go to IDLE and pulse done in the following cycle.
REQ-028 start SHALL be ignored when not in IDLE; S and M SHALL be held for the whole line.
REQ-029 m_valid SHALL never depend combinationally on m_ready.
REQ-030 Latency from an accepted start: NORM is entered the next cycle. For each output, the time is (number of NORM subtractions)+1 cycles, plus C_PHASE_BITS cycles when the output is interior.

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL enter IDLE and clear r, k, j, m_valid, busy, done, cfg_err, m_i0, m_i1, m_phase, m_idx, m_first and m_last to 0.
REQ-032 A reset in any state, including mid-line, SHALL abort the line with no done pulse; the next start SHALL begin a fresh line.

Verification
REQ-033 Expand test, S=2, M=4, P=4, m_ready=1: the (i0,i1,phase) sequence SHALL be (0,0,0), (0,1,4), (0,1,12), (1,1,0); m_first only on the first output, m_last only on the fourth; one done pulse.
REQ-034 Shrink test, S=4, M=2, P=4: the outputs SHALL be (0,1,8) then (2,3,8); the second output SHALL be preceded by 2 NORM subtraction cycles.
REQ-035 Unity test, S=M=3: the outputs SHALL be (0,1,0), (1,2,0), (2,2,0); cfg_err SHALL stay 0.
REQ-036 Backpressure test, S=2, M=4, with m_ready low for 5 cycles on each output: the outputs SHALL be held stable, with no loss or duplication, and the sequence SHALL be identical to REQ-033.
REQ-037 Error and abort test: start with M=0 -> a cfg_err pulse, busy stays 0. Then start with S=4, M=2, and assert reset in the second DIV cycle -> IDLE, all outputs 0, no done; a following start -> a full correct line.
